// File: rtl/cpcs_decoder_n.sv
// rtl/cpcs_decoder_n.sv - two-stage 8b/10b symbol decoder with running-disparity and error tracking
// Stage 1 captures the raw symbol; stage 2 decodes it against the running disparity and registers the results.
module cpcs_decoder_n #(
  parameter logic RD_INIT   = 1'b0,
  parameter int   ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [9:0]           DIN,
  input  logic                 DIN_VAL,
  input  logic                 RD_FORCE_EN,
  input  logic                 RD_FORCE_VAL,
  input  logic                 ERR_CNT_CLR,
  output logic [7:0]           D,
  output logic                 K,
  output logic                 DOUT_VAL,
  output logic                 CODE_ERR,
  output logic                 DISP_ERR,
  output logic                 COMMA,
  output logic                 RD_OUT,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [9:0]           din_q;
  logic                 val1_q;
  logic [7:0]           d_q, d_d;
  logic                 k_q, k_d, dval_q, cerr_q, cerr_d, derr_q, derr_d;
  logic                 comma_q, comma_d, rd_out_q, rd_q, rd_d, sym_rd;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] s6;
  logic [3:0] s4, s4x;
  logic [4:0] d5;
  logic [2:0] hgf;
  logic       ok6, ok4, k28, a7, p7, kx7, a7_ok, p7_bad;
  logic       pos6, neg6, pos4, neg4, rd6;

  always_comb begin
    s6  = din_q[9:4];
    s4  = din_q[3:0];
    d5  = 5'd0;
    ok6 = 1'b1;
    k28 = 1'b0;
    case (s6)
      6'b100111, 6'b011000: d5 = 5'd0;
      6'b011101, 6'b100010: d5 = 5'd1;
      6'b101101, 6'b010010: d5 = 5'd2;
      6'b110001:            d5 = 5'd3;
      6'b110101, 6'b001010: d5 = 5'd4;
      6'b101001:            d5 = 5'd5;
      6'b011001:            d5 = 5'd6;
      6'b111000, 6'b000111: d5 = 5'd7;
      6'b111001, 6'b000110: d5 = 5'd8;
      6'b100101:            d5 = 5'd9;
      6'b010101:            d5 = 5'd10;
      6'b110100:            d5 = 5'd11;
      6'b001101:            d5 = 5'd12;
      6'b101100:            d5 = 5'd13;
      6'b011100:            d5 = 5'd14;
      6'b010111, 6'b101000: d5 = 5'd15;
      6'b011011, 6'b100100: d5 = 5'd16;
      6'b100011:            d5 = 5'd17;
      6'b010011:            d5 = 5'd18;
      6'b110010:            d5 = 5'd19;
      6'b001011:            d5 = 5'd20;
      6'b101010:            d5 = 5'd21;
      6'b011010:            d5 = 5'd22;
      6'b111010, 6'b000101: d5 = 5'd23;
      6'b110011, 6'b001100: d5 = 5'd24;
      6'b100110:            d5 = 5'd25;
      6'b010110:            d5 = 5'd26;
      6'b110110, 6'b001001: d5 = 5'd27;
      6'b001110:            d5 = 5'd28;
      6'b101110, 6'b010001: d5 = 5'd29;
      6'b011110, 6'b100001: d5 = 5'd30;
      6'b101011, 6'b010100: d5 = 5'd31;
      6'b001111, 6'b110000: begin d5 = 5'd28; k28 = 1'b1; end
      default:              ok6 = 1'b0;
    endcase

    // K28 after 110000 uses the complement of the balanced 4b codes, so fold it back first.
    s4x = (k28 && s6 == 6'b110000) ? ~s4 : s4;
    hgf = 3'd0;
    ok4 = 1'b1;
    a7  = 1'b0;
    p7  = 1'b0;
    case (s4x)
      4'b1011, 4'b0100: hgf = 3'd0;
      4'b1001:          hgf = 3'd1;
      4'b0101:          hgf = 3'd2;
      4'b1100, 4'b0011: hgf = 3'd3;
      4'b1101, 4'b0010: hgf = 3'd4;
      4'b1010:          hgf = 3'd5;
      4'b0110:          hgf = 3'd6;
      4'b1110, 4'b0001: begin hgf = 3'd7; p7 = 1'b1; end
      4'b0111, 4'b1000: begin hgf = 3'd7; a7 = 1'b1; end
      default:          ok4 = 1'b0;
    endcase

    pos6 = ($countones(s6) == 4);
    neg6 = ($countones(s6) == 2);
    pos4 = ($countones(s4) == 3);
    neg4 = ($countones(s4) == 1);
    rd6    = (pos6 || s6 == 6'b000111) ? 1'b1 : ((neg6 || s6 == 6'b111000) ? 1'b0 : rd_q);
    sym_rd = (pos4 || s4 == 4'b0011)   ? 1'b1 : ((neg4 || s4 == 4'b1100)   ? 1'b0 : rd6);
    derr_d = (rd_q ? (pos6 || s6 == 6'b111000) : (neg6 || s6 == 6'b000111)) ||
             (rd6  ? (pos4 || s4 == 4'b1100)   : (neg4 || s4 == 4'b0011));

    kx7    = d5 inside {5'd23, 5'd27, 5'd29, 5'd30};
    p7_bad = k28 || (!rd6 && (d5 inside {5'd17, 5'd18, 5'd20})) ||
             (rd6 && (d5 inside {5'd11, 5'd13, 5'd14}));
    a7_ok  = k28 || kx7 || p7_bad;
    cerr_d = !ok6 || !ok4 || (a7 && !a7_ok) || (p7 && p7_bad && !kx7);
    k_d    = !cerr_d && (k28 || (a7 && kx7));
    d_d    = cerr_d ? 8'h00 : {hgf, d5};
    comma_d = ({s6, s4[3]} == 7'b0011111) || ({s6, s4[3]} == 7'b1100000);

    // A force on the same edge as a stage-2 symbol wins over that symbol's update.
    rd_d = RD_FORCE_EN ? RD_FORCE_VAL : (val1_q ? sym_rd : rd_q);
    cnt_d = cnt_q;
    if (ERR_CNT_CLR) cnt_d = '0;
    else if (dval_q && (cerr_q || derr_q) && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      din_q    <= 10'd0;
      val1_q   <= 1'b0;
      dval_q   <= 1'b0;
      d_q      <= 8'h00;
      k_q      <= 1'b0;
      cerr_q   <= 1'b0;
      derr_q   <= 1'b0;
      comma_q  <= 1'b0;
      rd_q     <= RD_INIT;
      rd_out_q <= RD_INIT;
      cnt_q    <= '0;
    end else begin
      din_q  <= DIN;
      val1_q <= DIN_VAL;
      dval_q <= val1_q;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      if (val1_q) begin
        d_q      <= d_d;
        k_q      <= k_d;
        cerr_q   <= cerr_d;
        derr_q   <= derr_d;
        comma_q  <= comma_d;
        rd_out_q <= sym_rd;
      end
    end
  end

  assign D        = d_q;
  assign K        = k_q;
  assign DOUT_VAL = dval_q;
  assign CODE_ERR = cerr_q;
  assign DISP_ERR = derr_q;
  assign COMMA    = comma_q;
  assign RD_OUT   = rd_out_q;
  assign ERR_CNT  = cnt_q;

endmodule
